// File: rtl/rr_arbiter16_pkg.sv
// Shared types and helpers for the 16-way round-robin arbiter.
// Holds sizes, the FSM state type and the rotating-priority pick.
package rr_arb_pkg;

  localparam int NREQ  = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set bit at or above ptr, wrapping 15 -> 0.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NREQ-1:0]  req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter16_if;
  import rr_arb_pkg::*;

  logic             en;
  logic [NREQ-1:0]  req;
  logic             done;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_arbiter16_decode.sv
// 4-to-16 one-hot decoder with enable.
// Output is all zeros while en is low.
module decode4to16 (
  input  logic [3:0]  A,
  input  logic        en,
  output logic [15:0] out
);

  // One-hot decode of A, gated by en
  always_comb begin
    out = 16'h0000;
    if (en) out[A] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters sharing one slot.
// Grant is held until done, request drop or hold timeout.
module rr_arbiter16
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_arbiter16_if.slave bus
);

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_n;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_n;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_idx_n;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             r_timeout;
  logic             w_to_n;
  logic             w_rel;
  logic             w_gnt_valid;
  logic [NREQ-1:0]  w_gnt;

  assign w_gnt_valid = (r_state == GRANT);
  assign w_rel = bus.done || !bus.req[r_gnt_idx];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt_idx  <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_ptr      <= w_ptr_n;
      r_gnt_idx  <= w_idx_n;
      r_hold_cnt <= w_cnt_n;
      r_timeout  <= w_to_n;
    end
  end

  // Next-state: pick in IDLE, release/timeout/count in GRANT
  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_idx_n   = r_gnt_idx;
    w_cnt_n   = r_hold_cnt;
    w_to_n    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.en && (bus.req != '0)) begin
          w_idx_n   = rr_pick(bus.req, r_ptr);
          w_cnt_n   = '0;
          w_state_n = GRANT;
        end
      end
      GRANT: begin
        if (w_rel) begin
          w_state_n = IDLE;
          w_ptr_n   = r_gnt_idx + 4'd1;
        end else if (TO_EN && (r_hold_cnt == LAST)) begin
          w_state_n = IDLE;
          w_ptr_n   = r_gnt_idx + 4'd1;
          w_to_n    = 1'b1;
        end else begin
          w_cnt_n = r_hold_cnt + CNT_W'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  decode4to16 u_dec (
    .A   (r_gnt_idx),
    .en  (w_gnt_valid),
    .out (w_gnt)
  );

  assign bus.gnt       = w_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = w_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 with TIMEOUT = 4.
// Table of vectors plus reset, rotation and async-reset sequences.
module tb_rr_arbiter16;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic        done;
    logic        v;
    logic [3:0]  idx;
    logic [15:0] gnt;
    logic        to;
  } vec_t;

  vec_t tbl[27];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic v,
                         input logic [3:0] idx,
                         input logic [15:0] g, input logic to);
    chk({nm, ".valid"}, int'(bus.gnt_valid), int'(v));
    chk({nm, ".idx"}, int'(bus.gnt_idx), int'(idx));
    chk({nm, ".gnt"}, int'(bus.gnt), int'(g));
    chk({nm, ".timeout"}, int'(bus.timeout), int'(to));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [15:0] r,
                       input logic d);
    bus.en   = e;
    bus.req  = r;
    bus.done = d;
  endtask

  initial begin
    logic [3:0] nx;
    n_chk = 0;
    n_err = 0;

    //          en  req       done v  idx    gnt       to
    tbl[0]  = '{1, 16'h2000, 0,   1, 4'd13, 16'h2000, 0};
    tbl[1]  = '{1, 16'h0000, 0,   0, 4'd13, 16'h0000, 0};
    tbl[2]  = '{1, 16'h0009, 0,   1, 4'd0,  16'h0001, 0};
    tbl[3]  = '{1, 16'h0009, 1,   0, 4'd0,  16'h0000, 0};
    tbl[4]  = '{1, 16'h0009, 0,   1, 4'd3,  16'h0008, 0};
    tbl[5]  = '{1, 16'h0009, 1,   0, 4'd3,  16'h0000, 0};
    tbl[6]  = '{1, 16'h0000, 0,   0, 4'd3,  16'h0000, 0};
    tbl[7]  = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[8]  = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[9]  = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[10] = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[11] = '{1, 16'h0020, 0,   0, 4'd5,  16'h0000, 1};
    tbl[12] = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[13] = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[14] = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[15] = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[16] = '{1, 16'h0020, 1,   0, 4'd5,  16'h0000, 0};
    tbl[17] = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[18] = '{1, 16'h0020, 0,   1, 4'd5,  16'h0020, 0};
    tbl[19] = '{1, 16'h0000, 0,   0, 4'd5,  16'h0000, 0};
    tbl[20] = '{0, 16'h0100, 0,   0, 4'd5,  16'h0000, 0};
    tbl[21] = '{0, 16'h0100, 0,   0, 4'd5,  16'h0000, 0};
    tbl[22] = '{1, 16'h0100, 0,   1, 4'd8,  16'h0100, 0};
    tbl[23] = '{0, 16'h0100, 0,   1, 4'd8,  16'h0100, 0};
    tbl[24] = '{0, 16'h0100, 0,   1, 4'd8,  16'h0100, 0};
    tbl[25] = '{0, 16'h0100, 1,   0, 4'd8,  16'h0000, 0};
    tbl[26] = '{1, 16'h0100, 0,   1, 4'd8,  16'h0100, 0};

    // Reset held with all requests pending
    rst_n = 1'b0;
    drive(1'b1, 16'hFFFF, 1'b0);
    #2;
    chk_all("rst0", 0, 4'd0, 16'h0, 0);
    step();
    chk_all("rst1", 0, 4'd0, 16'h0, 0);
    step();
    chk_all("rst2", 0, 4'd0, 16'h0, 0);
    rst_n = 1'b1;
    step();
    chk_all("first", 1, 4'd0, 16'h0001, 0);

    // Rotation 0..15,0 with one idle bubble per hand-off
    for (int k = 0; k < 16; k++) begin
      nx = 4'(k + 1);
      bus.done = 1'b1;
      step();
      chk_all($sformatf("rot%0d.bub", k), 0, 4'(k), 16'h0, 0);
      bus.done = 1'b0;
      step();
      chk_all($sformatf("rot%0d.gnt", k), 1, nx,
              16'h0001 << nx, 0);
    end
    bus.done = 1'b1;
    step();
    chk_all("rot.end", 0, 4'd0, 16'h0, 0);

    // Wrap/skip, timeout, simultaneous events, enable gating
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].en, tbl[i].req, tbl[i].done);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx,
              tbl[i].gnt, tbl[i].to);
    end

    // Async reset mid-grant drops it immediately, no timeout pulse
    drive(1'b1, 16'h0100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("arst", 0, 4'd0, 16'h0, 0);
    step();
    chk_all("arst.hold", 0, 4'd0, 16'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter that shares one 16-entry resource slot (one FIFO write port, selected by a 4-bit index) among 16 requesters. It picks one requester with rotating priority and holds the grant until the holder releases, drops its request or times out. It drives the existing `decode4to16` to produce the one-hot grant vector.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum number of cycles a grant is held. 0 disables the timeout.
- `CNT_W`, default 5: width of the hold counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: arbitration enable. When 0, no new grant starts; a grant already in progress continues.
- `req`, input, 16: request vector. `req[i]` is level-sensitive and stays high until served.
- `done`, input, 1: single-cycle release pulse from the current holder.
- `gnt`, output, 16: one-hot grant vector, all zeros when idle.
- `gnt_idx`, output, 4: index of the current holder.
- `gnt_valid`, output, 1: a grant is active.
- `timeout`, output, 1: single-cycle pulse flagging a forced release.

## Operation

- State machine with two states, IDLE and GRANT. Registers: `state`, `ptr[3:0]`, `gnt_idx[3:0]`, `hold_cnt[CNT_W-1:0]`, `timeout`.
- Reset values: state = IDLE, ptr = 0, gnt_idx = 0, gnt_valid = 0, gnt = 16'h0000, hold_cnt = 0, timeout = 0.
- Reset asserted mid-grant drops the grant immediately and asynchronously; no timeout pulse is produced.
- IDLE:
  - If en = 1 and `req != 0`, select the first set bit scanning upward from `ptr`, wrapping 15 -> 0.
  - Load `gnt_idx` with that index, clear hold_cnt, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - gnt_valid = 1.
  - gnt = `decode4to16(gnt_idx, en = gnt_valid)`.
- Release happens when, in a GRANT cycle, either `done` = 1 or `req[gnt_idx]` = 0.
  - Next state is IDLE.
  - ptr is set to gnt_idx + 1, modulo 16 (15 wraps to 0).
- Forced release happens when TIMEOUT != 0, hold_cnt == TIMEOUT-1 and no release occurs that cycle.
  - Next state is IDLE and ptr = gnt_idx + 1.
  - timeout = 1 for exactly that next cycle.
- Any other GRANT cycle: hold_cnt increments by 1.
- Release and timeout in the same cycle: release wins and timeout stays 0.
- `done` received in IDLE is ignored.
- `req` bits of non-holders have no effect during GRANT.
- en = 0 does not affect an active grant or the timeout.
- gnt_idx keeps its last value in IDLE; only gnt_valid and gnt are cleared.

## Timing

- Request to grant: 1 cycle. req sampled in IDLE at edge k gives gnt_valid = 1 from edge k onward.
- Release to drop: gnt_valid falls at the edge that samples done or the dropped req.
- Every grant is followed by at least one IDLE cycle, so there is a 1-cycle bubble between consecutive grants.
- Maximum hold is exactly TIMEOUT cycles with gnt_valid = 1.
- timeout rises together with the falling gnt_valid, for 1 cycle.
- All outputs are registered, except `gnt`, which is a combinational decode of registered gnt_idx and gnt_valid.

## Structure

- Package `rr_arb_pkg`:
  - `NREQ = 16`, `IDX_W = 4`.
  - State enum `arb_state_t` with values IDLE and GRANT.
  - Function `rr_pick(req, ptr)`, returning the index of the first set bit at or above ptr, with wrap.
- One sub-module, the existing `decode4to16`, instantiated as the one-hot grant decoder (`A = gnt_idx`, `en = gnt_valid`, `out = gnt`).
- Everything else lives in `rr_arbiter16`.

## Test plan

1. Reset behaviour: rst_n = 0 with req = 16'hFFFF. All outputs stay 0. Release reset, then en = 1: the next edge gives gnt_idx = 0 and gnt = 16'h0001.
2. Rotation: req = 16'hFFFF held, done pulsed on every grant. Grants come out 0, 1, 2 … 15, 0, with exactly one gnt_valid = 0 cycle between each pair.
3. Wrap and skip: ptr = 14 after a grant to 13, req = 16'h0009. The grant goes to 0, then to 3.
4. Timeout: TIMEOUT = 4, req[5] held, no done. gnt = 16'h0020 for exactly 4 cycles, then gnt_valid = 0 and timeout = 1 for 1 cycle, then req[5] is re-granted.
5. Simultaneous events: done on the same cycle hold_cnt reaches 3 (TIMEOUT = 4). The grant drops and timeout stays 0. The holder dropping req mid-grant also releases the grant.
6. Enable gating: en = 0 with req = 16'h0100 gives no grant. en falling during the grant to 8 keeps it held until done. Asserting rst_n = 0 mid-grant clears gnt asynchronously, with no timeout pulse.
